watchdog_seq: RTL and testbench
===============================

Name: watchdog_seq

Overview:
Top-level sequencer for the watchdog eigen-pipeline. It waits for the parameter loader to report a valid (a0, a1) pair, launches the eig_core calculation, then launches the output_loader serialisation. It supervises every busy handshake with a per-phase timeout counter and raises a sticky fault if either engine stalls. It sits between param_loader, eig_core and output_loader inside tt_um_watchdog and replaces ad-hoc start/busy glue.

Parameters:
ACK_WIN, 8, max cycles from a start pulse to the engine's busy rising (≥2)
TIMEOUT_CYCLES, 1024, max cycles an engine may hold busy high (≥2)
CNT_W, 16, wait-counter width; must hold max(ACK_WIN, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
ena  in  1  global enable; low = freeze
params_valid  in  1  1-cycle pulse from param_loader: a0/a1 captured
core_busy  in  1  eig_core busy
ol_busy  in  1  output_loader busy
clear_err  in  1  1-cycle pulse: leave ERR
core_start  out  1  1-cycle start pulse to eig_core
ol_start  out  1  1-cycle start pulse to output_loader
loader_hold  out  1  high = param_loader must not overwrite a0/a1
run_done  out  1  1-cycle pulse: full run completed
state  out  3  current FSM state encoding
timeout  out  1  sticky fault flag
err_phase  out  2  phase that faulted: 1=CALC_ACK 2=CALC 3=OUT_ACK/OUT, 0=none
overrun  out  1  sticky: params_valid arrived while not IDLE
run_count  out  8  completed runs, wraps 255->0

Behaviour:
- All outputs registered. On rst=1 at a clock edge: state=IDLE, wait_cnt=0, all pulses 0, loader_hold=0, timeout=0, err_phase=0, overrun=0, run_count=0. Reset overrides ena and aborts any phase immediately. No in-flight start is replayed.
- ena=0: state, wait_cnt, flags and run_count hold. core_start, ol_start and run_done are forced to 0. Inputs are ignored, including params_valid, which is lost and does not set overrun.
- States and encodings: IDLE=0, CALC_ACK=1, CALC=2, OUT_ACK=3, OUT=4, ERR=5. Codes 6/7 return to IDLE.
- IDLE: when params_valid=1, go to CALC_ACK. core_start=1 in that same next cycle, so latency from params_valid to core_start is 1 cycle.
- CALC_ACK: core_busy=1 goes to CALC. Otherwise, if wait_cnt==ACK_WIN-1, go to ERR with err_phase=1.
- CALC: core_busy=0 goes to OUT_ACK, with ol_start=1 in the entry cycle. Otherwise, if wait_cnt==TIMEOUT_CYCLES-1, go to ERR with err_phase=2.
- OUT_ACK: ol_busy=1 goes to OUT. Otherwise, if wait_cnt==ACK_WIN-1, go to ERR with err_phase=3.
- OUT: ol_busy=0 goes to IDLE, with run_done=1 in the entry cycle and run_count+1. Otherwise, if wait_cnt==TIMEOUT_CYCLES-1, go to ERR with err_phase=3.
- wait_cnt is cleared to 0 on every state entry and increments by 1 per enabled cycle in the four wait states. It never wraps, because the phase exits at the limit.
- If an exit condition and the timeout limit occur in the same cycle, the exit condition wins.
- ERR: timeout=1 and err_phase are latched. No starts are issued. clear_err=1 goes to IDLE and clears timeout and err_phase. overrun is cleared only by rst.
- loader_hold = (state != IDLE), registered with the state.
- params_valid=1 in any state other than IDLE, including ERR and the cycle where clear_err is accepted: the pulse is dropped and overrun is set to 1.
- An engine already busy when its start is issued is accepted as an ack on the next cycle; no separate check is made.

Test Plan:
- Nominal run: params_valid at cycle 10; core_busy high cycles 12–20; ol_busy high cycles 23–40 -> core_start=1 @11; ol_start=1 @22 (state 3); run_done=1 @42; run_count=1; state=0 @42; timeout=0.
- Core ack timeout, ACK_WIN=8: params_valid @0, core_busy held 0 -> state CALC_ACK @1–8; state=5, timeout=1, err_phase=1 @9. Then clear_err @15 -> state=0 @16, timeout=0.
- Calc stall, TIMEOUT_CYCLES=16: core_busy rises @2 and stays high -> CALC entered @3; ERR @19 with err_phase=2; ol_start never asserted.
- Overrun and freeze: params_valid pulsed @5 during CALC -> overrun=1, run unaffected. ena=0 for cycles 8–12 during OUT -> state and wait_cnt frozen, no run_done; run completes normally afterwards.
- Boundary and wrap: core_busy falls exactly in the cycle wait_cnt==TIMEOUT_CYCLES-1 -> OUT_ACK, no fault. Preload 255 runs, complete one more -> run_count=0.
- Reset mid-operation: rst=1 @ cycle in OUT with flags set -> next cycle state=0, loader_hold=0, timeout=0, overrun=0, run_count=0, no pulses.

Source files
------------

// File: rtl/watchdog_seq_if.sv
// watchdog_seq_if: start/busy handshake bundle for watchdog_seq.
// master = surrounding engines/loader, slave = the sequencer.
interface watchdog_seq_if;
  logic       params_valid;
  logic       core_busy;
  logic       ol_busy;
  logic       clear_err;
  logic       core_start;
  logic       ol_start;
  logic       loader_hold;
  logic       run_done;
  logic [2:0] state;
  logic       timeout;
  logic [1:0] err_phase;
  logic       overrun;
  logic [7:0] run_count;

  modport master (
    output params_valid, core_busy,
    output ol_busy, clear_err,
    input  core_start, ol_start,
    input  loader_hold, run_done,
    input  state, timeout, err_phase,
    input  overrun, run_count
  );

  modport slave (
    input  params_valid, core_busy,
    input  ol_busy, clear_err,
    output core_start, ol_start,
    output loader_hold, run_done,
    output state, timeout, err_phase,
    output overrun, run_count
  );
endinterface

// File: rtl/watchdog_seq.sv
// watchdog_seq: params -> eig_core -> output_loader sequencer.
// Each busy handshake is bounded by a per-phase wait counter.
module watchdog_seq #(
  parameter int ACK_WIN        = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  watchdog_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CACK = 3'd1,
    S_CALC = 3'd2,
    S_OACK = 3'd3,
    S_OUT  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LIM =
    CNT_W'(ACK_WIN - 1);
  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           st;
  logic [CNT_W-1:0] wait_cnt;
  logic             core_start;
  logic             ol_start;
  logic             loader_hold;
  logic             run_done;
  logic             timeout;
  logic [1:0]       err_phase;
  logic             overrun;
  logic [7:0]       run_count;

  logic pv;
  logic cb;
  logic ob;
  logic ce;

  assign pv = bus.params_valid;
  assign cb = bus.core_busy;
  assign ob = bus.ol_busy;
  assign ce = bus.clear_err;

  // Sequencer FSM with registered pulses, flags and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      wait_cnt    <= '0;
      core_start  <= 1'b0;
      ol_start    <= 1'b0;
      loader_hold <= 1'b0;
      run_done    <= 1'b0;
      timeout     <= 1'b0;
      err_phase   <= 2'd0;
      overrun     <= 1'b0;
      run_count   <= 8'd0;
    end else if (!ena) begin
      core_start <= 1'b0;
      ol_start   <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      ol_start   <= 1'b0;
      run_done   <= 1'b0;
      if (pv && st != S_IDLE)
        overrun <= 1'b1;
      case (st)
        S_IDLE: begin
          wait_cnt <= '0;
          if (pv) begin
            st          <= S_CACK;
            core_start  <= 1'b1;
            loader_hold <= 1'b1;
          end
        end
        S_CACK: begin
          if (cb) begin
            st       <= S_CALC;
            wait_cnt <= '0;
          end else if (wait_cnt == ACK_LIM) begin
            st        <= S_ERR;
            wait_cnt  <= '0;
            timeout   <= 1'b1;
            err_phase <= 2'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CALC: begin
          if (!cb) begin
            st       <= S_OACK;
            wait_cnt <= '0;
            ol_start <= 1'b1;
          end else if (wait_cnt == TO_LIM) begin
            st        <= S_ERR;
            wait_cnt  <= '0;
            timeout   <= 1'b1;
            err_phase <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OACK: begin
          if (ob) begin
            st       <= S_OUT;
            wait_cnt <= '0;
          end else if (wait_cnt == ACK_LIM) begin
            st        <= S_ERR;
            wait_cnt  <= '0;
            timeout   <= 1'b1;
            err_phase <= 2'd3;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (!ob) begin
            st          <= S_IDLE;
            wait_cnt    <= '0;
            loader_hold <= 1'b0;
            run_done    <= 1'b1;
            run_count   <= run_count + 8'd1;
          end else if (wait_cnt == TO_LIM) begin
            st        <= S_ERR;
            wait_cnt  <= '0;
            timeout   <= 1'b1;
            err_phase <= 2'd3;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ERR: begin
          wait_cnt <= '0;
          if (ce) begin
            st          <= S_IDLE;
            loader_hold <= 1'b0;
            timeout     <= 1'b0;
            err_phase   <= 2'd0;
          end
        end
        default: begin
          st          <= S_IDLE;
          wait_cnt    <= '0;
          loader_hold <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = st;
  assign bus.core_start  = core_start;
  assign bus.ol_start    = ol_start;
  assign bus.loader_hold = loader_hold;
  assign bus.run_done    = run_done;
  assign bus.timeout     = timeout;
  assign bus.err_phase   = err_phase;
  assign bus.overrun     = overrun;
  assign bus.run_count   = run_count;

endmodule

// File: tb/tb_watchdog_seq.sv
// tb_watchdog_seq: directed plus random stimulus for watchdog_seq,
// checked every cycle against a phase/elapsed-time reference model.
module tb_watchdog_seq;
  localparam int AW = 8;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  watchdog_seq_if bus ();

  watchdog_seq #(
    .ACK_WIN(AW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model: phase 0..5, enabled cycles spent in phase
  int m_ph = 0;
  int m_t = 0;
  int m_ep = 0;
  int m_runs = 0;
  bit m_cs = 0;
  bit m_os = 0;
  bit m_rd = 0;
  bit m_hold = 0;
  bit m_to = 0;
  bit m_ov = 0;

  task automatic chk(string tag, logic [7:0] got,
                     logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int nph;
    logic pv;
    logic cb;
    logic ob;
    logic ce;
    pv = bus.params_valid;
    cb = bus.core_busy;
    ob = bus.ol_busy;
    ce = bus.clear_err;
    if (rst) begin
      m_ph = 0; m_t = 0; m_ep = 0; m_runs = 0;
      m_cs = 0; m_os = 0; m_rd = 0;
      m_hold = 0; m_to = 0; m_ov = 0;
      return;
    end
    m_cs = 0;
    m_os = 0;
    m_rd = 0;
    if (!ena) return;
    nph = m_ph;
    if (pv && m_ph != 0) m_ov = 1;
    case (m_ph)
      0: if (pv) begin nph = 1; m_cs = 1; end
      1: begin
        if (cb) nph = 2;
        else if (m_t + 1 == AW) begin nph = 5; m_ep = 1; end
      end
      2: begin
        if (!cb) begin nph = 3; m_os = 1; end
        else if (m_t + 1 == TO) begin nph = 5; m_ep = 2; end
      end
      3: begin
        if (ob) nph = 4;
        else if (m_t + 1 == AW) begin nph = 5; m_ep = 3; end
      end
      4: begin
        if (!ob) begin
          nph = 0;
          m_rd = 1;
          m_runs = (m_runs + 1) % 256;
        end else if (m_t + 1 == TO) begin
          nph = 5;
          m_ep = 3;
        end
      end
      5: if (ce) begin nph = 0; m_to = 0; m_ep = 0; end
      default: nph = 0;
    endcase
    if (nph == 5 && m_ph != 5) m_to = 1;
    m_t = (nph == m_ph) ? m_t + 1 : 0;
    m_ph = nph;
    m_hold = (nph != 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("state", {5'd0, bus.state}, 8'(m_ph));
    chk("core_start", {7'd0, bus.core_start}, {7'd0, m_cs});
    chk("ol_start", {7'd0, bus.ol_start}, {7'd0, m_os});
    chk("run_done", {7'd0, bus.run_done}, {7'd0, m_rd});
    chk("loader_hold", {7'd0, bus.loader_hold}, {7'd0, m_hold});
    chk("timeout", {7'd0, bus.timeout}, {7'd0, m_to});
    chk("err_phase", {6'd0, bus.err_phase}, 8'(m_ep));
    chk("overrun", {7'd0, bus.overrun}, {7'd0, m_ov});
    chk("run_count", bus.run_count, 8'(m_runs));
  endtask

  task automatic drv(bit r, bit e, bit pv, bit cb,
                     bit ob, bit ce);
    rst = r;
    ena = e;
    bus.params_valid = pv;
    bus.core_busy = cb;
    bus.ol_busy = ob;
    bus.clear_err = ce;
    tick();
  endtask

  initial begin
    int cw;
    int cl;
    int ow;
    int olen;
    int guard;
    bit r_pv;
    bit r_cb;
    bit r_ob;
    bit r_ce;
    bit r_en;
    bit r_rst;
    cw = 0; cl = 0; ow = 0; olen = 0;

    // reset
    drv(1, 1, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 1, 1);
    chk("rst_state", {5'd0, bus.state}, 8'd0);
    chk("rst_runs", bus.run_count, 8'd0);

    // nominal run
    for (int c = 0; c <= 45; c++) begin
      drv(0, 1, c == 10, c >= 12 && c <= 20,
          c >= 23 && c <= 40, 0);
      if (c + 1 == 11)
        chk("nom_cs", {7'd0, bus.core_start}, 8'd1);
      if (c + 1 == 22) begin
        chk("nom_os", {7'd0, bus.ol_start}, 8'd1);
        chk("nom_oack", {5'd0, bus.state}, 8'd3);
      end
      if (c + 1 == 42) begin
        chk("nom_done", {7'd0, bus.run_done}, 8'd1);
        chk("nom_idle", {5'd0, bus.state}, 8'd0);
        chk("nom_runs", bus.run_count, 8'd1);
        chk("nom_to", {7'd0, bus.timeout}, 8'd0);
      end
    end

    // core ack timeout then clear
    for (int c = 0; c <= 16; c++) begin
      drv(0, 1, c == 0, 0, 0, c == 15);
      if (c + 1 == 8)
        chk("ack_wait", {5'd0, bus.state}, 8'd1);
      if (c + 1 == 9) begin
        chk("ack_err", {5'd0, bus.state}, 8'd5);
        chk("ack_to", {7'd0, bus.timeout}, 8'd1);
        chk("ack_ep", {6'd0, bus.err_phase}, 8'd1);
      end
      if (c + 1 == 16) begin
        chk("clr_idle", {5'd0, bus.state}, 8'd0);
        chk("clr_to", {7'd0, bus.timeout}, 8'd0);
      end
    end

    // calc stall
    for (int c = 0; c <= 36; c++) begin
      drv(0, 1, c == 0, c >= 2, 0, 0);
      if (c + 1 == 34)
        chk("stall_calc", {5'd0, bus.state}, 8'd2);
      if (c + 1 == 35) begin
        chk("stall_err", {5'd0, bus.state}, 8'd5);
        chk("stall_ep", {6'd0, bus.err_phase}, 8'd2);
      end
    end
    drv(0, 1, 0, 0, 0, 1);

    // overrun during CALC, freeze during OUT
    for (int c = 0; c <= 17; c++) begin
      drv(0, !(c >= 8 && c <= 12), c == 0 || c == 3,
          c >= 1 && c <= 4, c >= 6 && c <= 14, 0);
      if (c + 1 == 4)
        chk("ovr_set", {7'd0, bus.overrun}, 8'd1);
      if (c + 1 == 12)
        chk("frz_state", {5'd0, bus.state}, 8'd4);
      if (c + 1 == 16)
        chk("frz_done", {7'd0, bus.run_done}, 8'd1);
    end

    // core_busy falls on the last allowed CALC cycle
    for (int c = 0; c <= 40; c++) begin
      drv(0, 1, c == 0, c >= 1 && c <= 32,
          c >= 35 && c <= 36, 0);
      if (c + 1 == 34) begin
        chk("bnd_oack", {5'd0, bus.state}, 8'd3);
        chk("bnd_to", {7'd0, bus.timeout}, 8'd0);
      end
      if (c + 1 == 38)
        chk("bnd_done", {7'd0, bus.run_done}, 8'd1);
    end

    // run_count wrap
    guard = 0;
    while (m_runs != 255 && guard < 300) begin
      drv(0, 1, 1, 0, 0, 0);
      drv(0, 1, 0, 1, 0, 0);
      drv(0, 1, 0, 0, 0, 0);
      drv(0, 1, 0, 0, 1, 0);
      drv(0, 1, 0, 0, 0, 0);
      guard++;
    end
    chk("pre_wrap", bus.run_count, 8'd255);
    drv(0, 1, 1, 0, 0, 0);
    drv(0, 1, 0, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 1, 0);
    drv(0, 1, 0, 0, 0, 0);
    chk("wrap", bus.run_count, 8'd0);
    drv(0, 1, 1, 0, 0, 0);
    drv(0, 1, 0, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 1, 0);
    drv(0, 1, 0, 0, 0, 0);

    // reset in OUT with overrun set
    drv(0, 1, 1, 0, 0, 0);
    drv(0, 1, 1, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 1, 0);
    chk("mid_out", {5'd0, bus.state}, 8'd4);
    chk("mid_ovr", {7'd0, bus.overrun}, 8'd1);
    drv(1, 1, 0, 0, 1, 0);
    chk("mr_state", {5'd0, bus.state}, 8'd0);
    chk("mr_hold", {7'd0, bus.loader_hold}, 8'd0);
    chk("mr_ovr", {7'd0, bus.overrun}, 8'd0);
    chk("mr_runs", bus.run_count, 8'd0);
    chk("mr_to", {7'd0, bus.timeout}, 8'd0);
    chk("mr_done", {7'd0, bus.run_done}, 8'd0);

    // random engines, enables, overruns, clears, resets
    for (int i = 0; i < 4000; i++) begin
      if (m_cs) begin
        cw = $urandom_range(0, 9);
        cl = $urandom_range(1, 36);
      end
      if (m_os) begin
        ow = $urandom_range(0, 9);
        olen = $urandom_range(1, 36);
      end
      r_cb = 0;
      if (cw > 0) cw--;
      else if (cl > 0) begin cl--; r_cb = 1; end
      r_ob = 0;
      if (ow > 0) ow--;
      else if (olen > 0) begin olen--; r_ob = 1; end
      if (m_ph == 0) r_pv = ($urandom_range(0, 3) == 0);
      else r_pv = ($urandom_range(0, 40) == 0);
      if (m_ph == 5) r_ce = ($urandom_range(0, 3) == 0);
      else r_ce = ($urandom_range(0, 60) == 0);
      r_en = ($urandom_range(0, 11) != 0);
      r_rst = ($urandom_range(0, 999) == 0);
      drv(r_rst, r_en, r_pv, r_cb, r_ob, r_ce);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
